// File: rtl/nibble_pkg.sv
// ---------------------------------------------------------------------------
// nibble_pkg : shared constants for the sequential nibble subtractor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package nibble_pkg;

   localparam int NIB_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic MODE_SPLIT = 1'b0;
   localparam logic MODE_CHAIN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/nibble_sub_cell.sv
// ---------------------------------------------------------------------------
// nibble_sub_cell : combinational nibble subtractor with borrow in/out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nibble_sub_cell
   import nibble_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             bin,
   output logic [NIB_W-1:0] d,
   output logic             bout
);

   // Borrow is the sign bit of the zero-extended difference.
   assign {bout, d} = {1'b0, a} - {1'b0, b} - {{NIB_W{1'b0}}, bin};

endmodule

`default_nettype wire

// File: rtl/nibble_sub_seq.sv
// ---------------------------------------------------------------------------
// nibble_sub_seq : two-step nibble subtractor, split or borrow-chained mode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nibble_sub_seq #(
   parameter int NIB_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2*NIB_W-1:0] A,
   input  logic [2*NIB_W-1:0] B,
   input  logic               ctrl,
   output logic               busy,
   output logic               done,
   output logic [2*NIB_W-1:0] diff,
   output logic [1:0]         bout
);

   import nibble_pkg::*;

   logic [1:0]         r_state;
   logic [1:0]         w_next;
   logic [2*NIB_W-1:0] r_a;
   logic [2*NIB_W-1:0] r_b;
   logic               r_ctrl;
   logic [2*NIB_W-1:0] r_diff;
   logic [1:0]         r_bout;

   logic [NIB_W-1:0]   w_cell_a;
   logic [NIB_W-1:0]   w_cell_b;
   logic               w_cell_bin;
   logic [NIB_W-1:0]   w_cell_d;
   logic               w_cell_bout;

   // One cell is shared: HI selects the upper nibbles and, when chained, the LO borrow.
   assign w_cell_a   = (r_state == ST_HI) ? r_a[2*NIB_W-1:NIB_W] : r_a[NIB_W-1:0];
   assign w_cell_b   = (r_state == ST_HI) ? r_b[2*NIB_W-1:NIB_W] : r_b[NIB_W-1:0];
   assign w_cell_bin = (r_state == ST_HI) && (r_ctrl == MODE_CHAIN) && r_bout[0];

   nibble_sub_cell u_cell (
      .a    (w_cell_a),
      .b    (w_cell_b),
      .bin  (w_cell_bin),
      .d    (w_cell_d),
      .bout (w_cell_bout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_next = ST_LO;
         ST_LO:   w_next = ST_HI;
         ST_HI:   w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != ST_IDLE);
      done = (r_state == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_ctrl <= MODE_SPLIT;
         r_diff <= '0;
         r_bout <= 2'b00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a    <= A;
                  r_b    <= B;
                  r_ctrl <= ctrl;
               end
            end
            ST_LO: begin
               r_diff[NIB_W-1:0] <= w_cell_d;
               r_bout[0]         <= w_cell_bout;
            end
            ST_HI: begin
               r_diff[2*NIB_W-1:NIB_W] <= w_cell_d;
               r_bout[1]               <= w_cell_bout;
            end
            default: ;
         endcase
      end
   end

   assign diff = r_diff;
   assign bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_nibble_sub_seq.sv
// ---------------------------------------------------------------------------
// tb_nibble_sub_seq : directed and random checks against an arithmetic model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_nibble_sub_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic       ctrl;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic [1:0] bout;

   int checks;
   int errors;
   logic [9:0] prev_res;

   nibble_sub_seq #(.NIB_W(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .ctrl  (ctrl),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns {bout[1], bout[0], diff} from plain integer arithmetic.
   function automatic logic [9:0] model(input int a, input int b, input bit c);
      int lo;
      int hi;
      int d;
      bit b0;
      bit b1;
      lo = (a % 16) - (b % 16);
      b0 = (lo < 0);
      if (c) begin
         d  = (a - b) & 255;
         b1 = (a < b);
      end else begin
         hi = (a / 16) - (b / 16);
         d  = ((hi & 15) * 16) + (lo & 15);
         b1 = (hi < 0);
      end
      return {b1, b0, d[7:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [9:0] exp, input bit stray);
      int n;
      A = a; B = b; ctrl = c; start = 1'b1;
      step();
      // LO state: nothing stored yet, previous result still visible
      start = stray;
      A = stray ? 8'hFF : 8'($urandom);
      B = 8'($urandom);
      ctrl = 1'($urandom);
      check("busy_lo", busy, 1);
      check("done_lo", done, 0);
      check("hold_prev", {bout, diff}, prev_res);
      step();
      // HI state: new low nibble alongside old high nibble
      check("busy_hi", busy, 1);
      check("lo_nib_hi", {bout[0], diff[3:0]}, {exp[8], exp[3:0]});
      check("hi_nib_old", {bout[1], diff[7:4]}, {prev_res[9], prev_res[7:4]});
      n = 2;
      while (!done && n < 8) begin
         step();
         n++;
      end
      start = 1'b0;
      check("latency", n, 3);
      check("busy_done", busy, 1);
      check("result", {bout, diff}, exp);
      step();
      check("done_pulse", done, 0);
      check("idle_busy", busy, 0);
      check("hold_after", {bout, diff}, exp);
      prev_res = exp;
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      int         n;
      checks = 0;
      errors = 0;
      prev_res = '0;
      rst = 1'b1; start = 1'b1; A = 8'hAA; B = 8'h55; ctrl = 1'b1;
      step();
      step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out", {bout, diff}, 10'h000);
      rst = 1'b0; start = 1'b0;
      step();
      check("idle_busy0", busy, 0);

      run_op(8'h81, 8'h24, 1'b0, 10'h16D, 1'b0);
      run_op(8'h81, 8'h24, 1'b1, 10'h15D, 1'b0);
      run_op(8'h12, 8'h8F, 1'b1, 10'h383, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b1, 10'h000, 1'b0);
      run_op(8'h09, 8'h63, 1'b0, 10'h2A6, 1'b1);
      step();
      check("stray_ignored", busy, 0);

      // Reset in HI aborts the operation
      A = 8'h0D; B = 8'h8D; ctrl = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_out", {bout, diff}, 10'h000);
      n = 0;
      repeat (3) begin
         step();
         if (done) n++;
      end
      check("abort_no_done", n, 0);
      prev_res = '0;
      run_op(8'h0D, 8'h8D, 1'b1, 10'h280, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         run_op(ra, rb, rc, model(ra, rb, rc), 1'($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
